alu_issue_ctrl: RTL and testbench

- Initiator side of the 64-bit ALU interface: decodes an incoming RV64 instruction into ALUOp/func3, drives registered operands to the ALU, and samples Result/Zero/Is_lesser one cycle later.
- Produces the writeback result and the branch decision/target, with valid/ready handshakes on both sides.
- Sits in the execute stage between register-read and the memory/writeback stage.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_op_decoder.sv | 65 ++++++
 rtl/alu_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ALUOp codes, RV64 opcodes,
// branch funct3 values, FSM state encoding and the decoder output bundle.
package alu_pkg;

    localparam int XLEN = 64;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_NOR = 4'b1100,
        ALU_SLL = 4'b1000
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // func3 values seen by the ALU; NONE keeps Zero and Is_lesser inert
    localparam logic [2:0] AF3_EQ   = 3'b000;
    localparam logic [2:0] AF3_LT   = 3'b100;
    localparam logic [2:0] AF3_NONE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_DONE
    } state_e;

    typedef struct packed {
        alu_op_e    op;
        logic [2:0] func3;
        logic       use_imm;
        logic       is_branch;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV64 decode of opcode/funct3/funct7[5] into ALU controls.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output dec_t       o_dec
);

    always_comb begin
        // Unsupported encodings fall through as an illegal ADD on rs1/rs2
        o_dec.op        = ALU_ADD;
        o_dec.func3     = AF3_NONE;
        o_dec.use_imm   = 1'b0;
        o_dec.is_branch = 1'b0;
        o_dec.illegal   = 1'b1;
        case (i_opcode)
            OPC_OP: begin
                case (i_funct3)
                    3'b000: begin
                        o_dec.op      = i_funct7b5 ? ALU_SUB : ALU_ADD;
                        o_dec.illegal = 1'b0;
                    end
                    3'b111: begin o_dec.op = ALU_AND; o_dec.illegal = 1'b0; end
                    3'b110: begin o_dec.op = ALU_OR;  o_dec.illegal = 1'b0; end
                    3'b001: begin o_dec.op = ALU_SLL; o_dec.illegal = 1'b0; end
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                case (i_funct3)
                    3'b000: begin o_dec.op = ALU_ADD; o_dec.use_imm = 1'b1; o_dec.illegal = 1'b0; end
                    3'b111: begin o_dec.op = ALU_AND; o_dec.use_imm = 1'b1; o_dec.illegal = 1'b0; end
                    3'b110: begin o_dec.op = ALU_OR;  o_dec.use_imm = 1'b1; o_dec.illegal = 1'b0; end
                    3'b001: begin o_dec.op = ALU_SLL; o_dec.use_imm = 1'b1; o_dec.illegal = 1'b0; end
                    default: ;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                o_dec.use_imm = 1'b1;
                o_dec.illegal = 1'b0;
            end
            OPC_BRANCH: begin
                case (i_funct3)
                    F3_BEQ, F3_BNE: begin
                        o_dec.op        = ALU_SUB;
                        o_dec.func3     = AF3_EQ;
                        o_dec.is_branch = 1'b1;
                        o_dec.illegal   = 1'b0;
                    end
                    F3_BLT, F3_BGE: begin
                        o_dec.op        = ALU_SUB;
                        o_dec.func3     = AF3_LT;
                        o_dec.is_branch = 1'b1;
                        o_dec.illegal   = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage initiator for the 64-bit ALU: registers decode/operands, waits one
// cycle for the ALU, captures result and branch decision, then hands off downstream.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [2:0]      alu_func3,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            alu_is_lesser,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_branch_taken,
    output logic [XLEN-1:0] out_branch_target,
    output logic            out_illegal
);

    state_e          r_state, w_next;
    dec_t            w_dec;
    logic            w_ready_st, w_valid_st, w_accept, w_taken;
    logic [XLEN-1:0] r_alu_a, r_alu_b, r_result, r_target;
    logic [3:0]      r_alu_op;
    logic [2:0]      r_alu_func3, r_br_f3;
    logic            r_is_branch, r_illegal, r_taken;
    logic            w_unused_bits;

    assign w_unused_bits = ^{in_instr[31], in_instr[29:15], in_instr[11:7]};

    alu_op_decoder u_dec (
        .i_opcode   (in_instr[6:0]),
        .i_funct3   (in_instr[14:12]),
        .i_funct7b5 (in_instr[30]),
        .o_dec      (w_dec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_ready_st = 1'b0;
        w_valid_st = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready_st = 1'b1;
                if (in_valid) w_next = ST_ISSUE;
            end
            ST_ISSUE:   w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_DONE;
            ST_DONE: begin
                w_valid_st = 1'b1;
                w_ready_st = out_ready;
                if (out_ready) w_next = in_valid ? ST_ISSUE : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Gating with reset keeps in_ready low while reset is held
    assign in_ready = w_ready_st & reset;
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_taken = 1'b0;
        if (r_is_branch) begin
            case (r_br_f3)
                F3_BEQ:  w_taken = alu_zero;
                F3_BNE:  w_taken = |alu_result;
                F3_BLT:  w_taken = ~alu_is_lesser;
                F3_BGE:  w_taken = alu_is_lesser;
                default: w_taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_alu_func3 <= '0;
            r_br_f3     <= '0;
            r_is_branch <= 1'b0;
            r_illegal   <= 1'b0;
            r_target    <= '0;
            r_result    <= '0;
            r_taken     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a     <= in_rs1;
                r_alu_b     <= w_dec.use_imm ? in_imm : in_rs2;
                r_alu_op    <= w_dec.op;
                r_alu_func3 <= w_dec.func3;
                r_br_f3     <= in_instr[14:12];
                r_is_branch <= w_dec.is_branch;
                r_illegal   <= w_dec.illegal;
                r_target    <= in_pc + in_imm;
            end
            if (r_state == ST_CAPTURE) begin
                r_result <= alu_result;
                r_taken  <= w_taken;
            end
        end
    end

    assign alu_a             = r_alu_a;
    assign alu_b             = r_alu_b;
    assign alu_op            = r_alu_op;
    assign alu_func3         = r_alu_func3;
    assign out_valid         = w_valid_st;
    assign out_result        = r_result;
    assign out_branch_taken  = r_taken;
    assign out_branch_target = r_target;
    assign out_illegal       = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed + randomized bench for alu_issue_ctrl with a behavioural ALU and an
// instruction-level reference model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_rs1, in_rs2, in_imm, in_pc;
    logic [63:0] alu_a, alu_b, alu_result, out_result, out_branch_target;
    logic [3:0]  alu_op;
    logic [2:0]  alu_func3;
    logic        alu_zero, alu_is_lesser, out_branch_taken, out_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_func3(alu_func3),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_is_lesser(alu_is_lesser),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_branch_taken(out_branch_taken), .out_branch_target(out_branch_target),
        .out_illegal(out_illegal)
    );

    // Behavioural ALU on the far side of the interface
    function automatic logic [63:0] alu_fn(logic [3:0] op, logic [63:0] a, logic [63:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b1100: return ~(a | b);
            4'b1000: return a << b[5:0];
            default: return 64'd0;
        endcase
    endfunction

    assign alu_result    = alu_fn(alu_op, alu_a, alu_b);
    assign alu_zero      = (alu_func3 == 3'b000) && (alu_result == 64'd0);
    assign alu_is_lesser = !((alu_func3 == 3'b100) && alu_result[63]);

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  f3;
        logic [63:0] b;
        logic [63:0] res;
        logic        taken;
        logic        ill;
    } exp_t;

    // Instruction-level expectation: what the instruction means, not how it is decoded
    function automatic exp_t ref_model(logic [31:0] ins, logic [63:0] rs1, logic [63:0] rs2,
                                       logic [63:0] imm);
        exp_t        e;
        logic [2:0]  f3 = ins[14:12];
        logic [63:0] d  = rs1 - rs2;
        e.op = 4'b0010; e.f3 = 3'b111; e.b = rs2; e.res = rs1 + rs2; e.taken = 1'b0; e.ill = 1'b1;
        case (ins[6:0])
            7'h33: case (f3)
                3'd0: begin e.ill = 1'b0; if (ins[30]) begin e.op = 4'b0110; e.res = d; end end
                3'd7: begin e.ill = 1'b0; e.op = 4'b0000; e.res = rs1 & rs2; end
                3'd6: begin e.ill = 1'b0; e.op = 4'b0001; e.res = rs1 | rs2; end
                3'd1: begin e.ill = 1'b0; e.op = 4'b1000; e.res = rs1 << rs2[5:0]; end
                default: ;
            endcase
            7'h13: case (f3)
                3'd0: begin e.ill = 1'b0; e.b = imm; e.res = rs1 + imm; end
                3'd7: begin e.ill = 1'b0; e.b = imm; e.op = 4'b0000; e.res = rs1 & imm; end
                3'd6: begin e.ill = 1'b0; e.b = imm; e.op = 4'b0001; e.res = rs1 | imm; end
                3'd1: begin e.ill = 1'b0; e.b = imm; e.op = 4'b1000; e.res = rs1 << imm[5:0]; end
                default: ;
            endcase
            7'h03, 7'h23: begin e.ill = 1'b0; e.b = imm; e.res = rs1 + imm; end
            7'h63: if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5) begin
                e.ill = 1'b0; e.op = 4'b0110; e.res = d;
                e.f3  = f3[2] ? 3'b100 : 3'b000;
                case (f3)
                    3'd0:    e.taken = (rs1 == rs2);
                    3'd1:    e.taken = (rs1 != rs2);
                    3'd4:    e.taken = d[63];
                    default: e.taken = !d[63];
                endcase
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] mk(logic [6:0] opc, logic [2:0] f3, logic f7b);
        return {1'b0, f7b, 5'd0, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; the caller arranges that in_ready is high on entry
    task automatic txn(input logic [31:0] ins, input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic [63:0] imm, input logic [63:0] pc, input int stall);
        exp_t        e   = ref_model(ins, rs1, rs2, imm);
        logic [63:0] tgt = pc + imm;
        in_instr = ins; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc; in_valid = 1'b1;
        #1;
        chk("in_ready_at_accept", 64'(in_ready), 64'd1);
        tick();
        // ISSUE: present junk that must be ignored while busy
        out_ready = 1'b0;
        in_instr = $urandom; in_rs1 = {$urandom, $urandom}; in_rs2 = {$urandom, $urandom};
        in_imm = {$urandom, $urandom}; in_pc = {$urandom, $urandom};
        chk("issue_alu_op", 64'(alu_op), 64'(e.op));
        chk("issue_alu_func3", 64'(alu_func3), 64'(e.f3));
        chk("issue_alu_a", alu_a, rs1);
        chk("issue_alu_b", alu_b, e.b);
        chk("issue_out_valid", 64'(out_valid), 64'd0);
        chk("issue_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("capture_alu_a", alu_a, rs1);
        chk("capture_alu_b", alu_b, e.b);
        chk("capture_out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("done_out_valid", 64'(out_valid), 64'd1);
        chk("done_result", out_result, e.res);
        chk("done_taken", 64'(out_branch_taken), 64'(e.taken));
        chk("done_target", out_branch_target, tgt);
        chk("done_illegal", 64'(out_illegal), 64'(e.ill));
        chk("done_in_ready_blocked", 64'(in_ready), 64'd0);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_result", out_result, e.res);
            chk("stall_taken", 64'(out_branch_taken), 64'(e.taken));
            chk("stall_alu_a", alu_a, rs1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic go_idle();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] rs1, rs2, imm, pc;
        logic [31:0] ins;
        logic [11:0] r12;
        logic [6:0]  opcs [0:5];
        opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h03;
        opcs[3] = 7'h23; opcs[4] = 7'h63; opcs[5] = 7'h73;

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_target", out_branch_target, 64'd0);
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        // add, then beq with 5-cycle backpressure, then back-to-back blt
        txn(mk(7'h33, 3'd0, 1'b0), 64'd5, 64'd7, 64'd0, 64'h40, 0);
        chk("add_result_12", out_result, 64'd12);
        go_idle();
        txn(mk(7'h63, 3'd0, 1'b0), 64'h10, 64'h10, 64'h20, 64'h100, 5);
        chk("beq_target", out_branch_target, 64'h120);
        chk("beq_taken", 64'(out_branch_taken), 64'd1);
        out_ready = 1'b1;
        txn(mk(7'h63, 3'd4, 1'b0), -64'sd3, 64'd4, 64'h8, 64'h200, 1);
        chk("blt_taken", 64'(out_branch_taken), 64'd1);
        out_ready = 1'b1;
        txn(mk(7'h63, 3'd5, 1'b0), -64'sd3, 64'd4, 64'h8, 64'h200, 0);
        chk("bge_taken", 64'(out_branch_taken), 64'd0);
        out_ready = 1'b1;
        txn(mk(7'h73, 3'd0, 1'b0), 64'd9, 64'd1, 64'd0, 64'h300, 0);
        chk("illegal_flag", 64'(out_illegal), 64'd1);
        out_ready = 1'b1;
        txn(mk(7'h63, 3'd2, 1'b0), 64'd9, 64'd9, 64'h4, 64'h304, 0);
        go_idle();

        // Reset during CAPTURE drops the instruction
        in_instr = mk(7'h33, 3'd0, 1'b1); in_rs1 = 64'd50; in_rs2 = 64'd8;
        in_imm = 64'h10; in_pc = 64'h500; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_alu_a", alu_a, 64'd0);
        chk("midrst_alu_op", 64'(alu_op), 64'd0);
        chk("midrst_result", out_result, 64'd0);
        chk("midrst_target", out_branch_target, 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_release_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("midrst_no_valid", 64'(out_valid), 64'd0);
        end

        // Randomized traffic with random stalls and back-to-back accepts
        for (int n = 0; n < 60; n++) begin
            ins = $urandom;
            ins[6:0] = ($urandom_range(0, 6) == 6) ? 7'($urandom) : opcs[$urandom_range(0, 5)];
            rs1 = {$urandom, $urandom};
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : {$urandom, $urandom};
            r12 = 12'($urandom);
            imm = {{52{r12[11]}}, r12};
            pc  = {$urandom, $urandom};
            txn(ins, rs1, rs2, imm, pc, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 0) go_idle();
            else out_ready = 1'b1;
        end
        go_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
